// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 1-cycle-read SRAM, with registered per-port read responses.
// Optional grant/conflict performance counters are enabled by defining SRAM_ARB_PERF_CNT_EN.
module sram_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic                  sram_cen_n,
    output logic                  sram_wen_n,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_d,
    input  logic [DATA_W-1:0]     sram_q
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]           perf_grant0,
    output logic [15:0]           perf_grant1,
    output logic [15:0]           perf_conflict
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic                r_rr_ptr;
    logic [CNT_W-1:0]    r_starve [2];
    logic                r_pend_vld;
    logic                r_pend_port;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata [2];
    logic [ADDR_W-1:0]   r_last_a;
    logic [DATA_W-1:0]   r_last_d;

    logic [1:0]          w_inflight;
    logic [1:0]          w_elig;
    logic                w_grant;
    logic                w_win;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // A read blocks its port until the response slot has been drained.
    always_comb begin
        w_inflight = {r_pend_vld & r_pend_port, r_pend_vld & ~r_pend_port};
        w_elig     = '0;
        for (int p = 0; p < 2; p++) begin
            w_elig[p] = reset & req_valid[p]
                        & (req_we[p] | (~r_rsp_valid[p] & ~w_inflight[p]));
        end
    end

    always_comb begin
        w_grant = |w_elig;
        w_win   = 1'b0;
        case (w_elig)
            2'b01: w_win = 1'b0;
            2'b10: w_win = 1'b1;
            2'b11: begin
                if (r_starve[0] == STARVE_LIM && r_starve[1] != STARVE_LIM)
                    w_win = 1'b0;
                else if (r_starve[1] == STARVE_LIM && r_starve[0] != STARVE_LIM)
                    w_win = 1'b1;
                else
                    w_win = r_rr_ptr;
            end
            default: w_win = 1'b0;
        endcase
    end

    always_comb begin
        w_sel_we    = w_win ? req_we[1] : req_we[0];
        w_sel_addr  = w_win ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
        w_sel_wdata = w_win ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
        req_ready   = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        sram_cen_n  = ~w_grant;
        sram_wen_n  = w_grant ? ~w_sel_we : 1'b1;
        sram_a      = '0;
        sram_d      = '0;
        if (reset) begin
            sram_a = w_grant ? w_sel_addr  : r_last_a;
            sram_d = w_grant ? w_sel_wdata : r_last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rr_ptr       <= 1'b0;
            r_starve[0]    <= '0;
            r_starve[1]    <= '0;
            r_pend_vld     <= 1'b0;
            r_pend_port    <= 1'b0;
            r_rsp_valid    <= '0;
            r_rsp_rdata[0] <= '0;
            r_rsp_rdata[1] <= '0;
            r_last_a       <= '0;
            r_last_d       <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= ~w_win;
                r_last_a <= w_sel_addr;
                r_last_d <= w_sel_wdata;
            end
            r_pend_vld  <= w_grant & ~w_sel_we;
            r_pend_port <= w_win;
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] || (w_grant && w_win == 1'(p)))
                    r_starve[p] <= '0;
                else if (w_elig[p] && r_starve[p] != STARVE_LIM)
                    r_starve[p] <= r_starve[p] + 1'b1;

                // sram_q is only meaningful the cycle after a read issue.
                if (r_pend_vld && r_pend_port == 1'(p)) begin
                    r_rsp_valid[p] <= 1'b1;
                    r_rsp_rdata[p] <= sram_q;
                end else if (rsp_ready[p]) begin
                    r_rsp_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = {r_rsp_rdata[1], r_rsp_rdata[0]};

`ifdef SRAM_ARB_PERF_CNT_EN
    logic [15:0] r_perf_g0;
    logic [15:0] r_perf_g1;
    logic [15:0] r_perf_conf;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_g0   <= '0;
            r_perf_g1   <= '0;
            r_perf_conf <= '0;
        end else begin
            if (w_grant && !w_win && r_perf_g0 != 16'hFFFF)
                r_perf_g0 <= r_perf_g0 + 16'd1;
            if (w_grant && w_win && r_perf_g1 != 16'hFFFF)
                r_perf_g1 <= r_perf_g1 + 16'd1;
            if (w_elig == 2'b11 && r_perf_conf != 16'hFFFF)
                r_perf_conf <= r_perf_conf + 16'd1;
        end
    end

    assign perf_grant0   = r_perf_g0;
    assign perf_grant1   = r_perf_g1;
    assign perf_conflict = r_perf_conf;
`endif

endmodule
